// File: rtl/mx8_rr_arbiter.sv
// mx8_rr_arbiter: round-robin arbiter that grants one of 8 lanes the shared
// result path. It holds each grant for up to MAX_BURST beats and drives the
// select of an 8-to-1 mux tree.
module mx8_rr_arbiter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           req,
    input  logic [7:0]           last,
    input  logic [8*WIDTH-1:0]   data_in,
    input  logic                 out_ready,
    output logic [7:0]           gnt,
    output logic [2:0]           sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         sel_q, sel_d;
    logic [7:0]         gnt_q, gnt_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [2:0]         winner;
    logic               win_found;
    logic [2:0]         scan_idx;

    logic [7:0][WIDTH-1:0] lane;
    logic [3:0][WIDTH-1:0] mux_l1;
    logic [1:0][WIDTH-1:0] mux_l2;

    // Round-robin scan: first requesting lane at or after ptr, wrapping 7 -> 0.
    always_comb begin
        win_found = 1'b0;
        winner    = ptr_q;
        scan_idx  = ptr_q;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;

        if (state_q == IDLE) begin
            gnt_d = 8'h00;
            if (win_found) begin
                sel_d      = winner;
                gnt_d      = 8'(1) << winner;
                beat_cnt_d = '0;
                state_d    = GRANT;
            end
        end else begin
            if (!req[sel_q]) begin
                // Lane withdrew: release with no transfer.
                gnt_d   = 8'h00;
                ptr_d   = sel_q + 3'd1;
                state_d = IDLE;
            end else if (out_ready) begin
                if (last[sel_q] || (beat_cnt_q == BURST_LAST)) begin
                    gnt_d   = 8'h00;
                    ptr_d   = sel_q + 3'd1;
                    state_d = IDLE;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State register with synchronous reset; reset abandons any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            sel_q      <= 3'd0;
            gnt_q      <= 8'h00;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Split the flat lane bus into per-lane words.
    assign lane = data_in;

    // Mux tree level 1: pairs selected by sel[0].
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mux_l1[i] = sel_q[0] ? lane[2*i+1] : lane[2*i];
        end
    end

    // Mux tree level 2: quads selected by sel[1].
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mux_l2[i] = sel_q[1] ? mux_l1[2*i+1] : mux_l1[2*i];
        end
    end

    assign out_data  = sel_q[2] ? mux_l2[1] : mux_l2[0];
    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = (state_q == GRANT);
    assign out_valid = (state_q == GRANT) && req[sel_q];

endmodule

// File: doc/mx8_rr_arbiter.md
Name: mx8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit result path between 8 requesters.
- Drives the 3-bit select of the 8-to-1 mux tree (s2,s1,s0 = sel[2],sel[1],sel[0]) and holds the grant across a multi-beat burst.
- Sits between the per-lane ALU result sources and the single downstream consumer, which applies valid/ready backpressure.

Parameters:
- WIDTH, 4, bit width of each lane's data and of out_data.
- MAX_BURST, 4, maximum beats per grant before forced release (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  8  per-lane request; held high while the lane has data to send.
- last  input  8  per-lane end-of-burst flag, qualified with the lane's beat.
- data_in  input  8*WIDTH  lane i data at bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- out_ready  input  1  downstream accepts a beat.
- gnt  output  8  one-hot grant; all zero when idle.
- sel  output  3  registered mux select, equal to the granted lane index.
- out_valid  output  1  beat valid toward downstream.
- out_data  output  WIDTH  data_in lane selected by sel, through the 8-to-1 mux tree.
- busy  output  1  high in GRANT state.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ptr=0, sel=0, gnt=0, beat_cnt=0, out_valid=0, busy=0.
- Reset asserted mid-burst aborts the burst at that edge. The in-flight beat is lost, and nothing is retained.
- Internal state:
  - ptr[2:0]: round-robin priority pointer.
  - beat_cnt: width sufficient to hold MAX_BURST.
- FSM with two states, IDLE and GRANT.
- IDLE:
  - gnt=0, out_valid=0.
  - If req != 0: winner = first set bit of req scanning ptr, ptr+1, ... wrapping 7→0.
  - On the clock edge: sel<=winner, gnt<=onehot(winner), beat_cnt<=0, state<=GRANT.
  - If req == 0: stay in IDLE; sel and ptr hold.
  - Arbitration latency: request seen at edge N gives gnt at edge N+1.
- GRANT:
  - busy=1, out_valid = req[sel] (combinational), out_data = lane sel.
  - Beat transfer occurs on an edge where out_valid && out_ready; beat_cnt increments.
  - Release conditions, evaluated at the edge:
    - (a) transfer with last[sel]=1;
    - (b) transfer making beat_cnt+1 == MAX_BURST;
    - (c) req[sel]=0, meaning the lane withdrew (no transfer occurs).
  - On release: gnt<=0, ptr<=sel+1 mod 8, state<=IDLE. sel holds its value.
  - out_ready low: the beat is held with no count change and no release, except by (c).
- Inter-grant gap: exactly one IDLE cycle between consecutive grants, including re-grant to the same lane.
- Fairness: after lane k releases, lane k has lowest priority. With all 8 lanes requesting continuously, grants cycle through every lane once every 8 grants.
- Requests on other lanes during GRANT are ignored until IDLE. No preemption.
- last on non-granted lanes is ignored. last with no transfer is ignored.
- gnt is always one-hot or zero and is consistent with sel while busy.
- out_data is the sel lane at all times; its value is don't-care when out_valid=0.

Test Plan:
- Reset then req=8'b0000_0100, last[2]=1 on first beat, out_ready=1, data lane2=4'hA:
  - gnt=8'h04 and sel=2 one cycle after req.
  - out_data=4'hA with out_valid=1 for one beat.
  - Next cycle gnt=0, ptr=3.
- req=8'hFF held, last=8'hFF, out_ready=1 from reset:
  - Grant order 0,1,2,...,7,0.
  - Each grant lasts one beat, with one IDLE cycle between grants.
- req[5] held, last=0, MAX_BURST=4:
  - Exactly 4 beats transferred, then release.
  - After one IDLE cycle, lane 5 is re-granted.
- Lane 3 granted, out_ready=0 for 3 cycles, then 1:
  - out_valid stays high, beat_cnt stays 0, gnt=8'h08 held.
  - Transfer occurs on the first ready edge.
- Lane 6 granted, req[6] drops before any transfer while req[1]=1:
  - Release with no beat transferred, ptr=7.
  - Next grant goes to lane 1 via wrap-around (7→0→1, first set bit).
- rst asserted during the 2nd beat of a lane-4 burst:
  - Next cycle gnt=0, sel=0, out_valid=0, busy=0.
  - After rst drops with req=8'h11, lane 0 is granted first (ptr=0).
